riu_wr_iodelay: RTL and testbench
=================================

RIU_WR_IODELAY -- requirements
Module: riu_wr_iodelay

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16'd1023, maximum cycles spent in WAIT_FOR_VALID with valid_i low; 0 disables the timeout.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 trig_re  in  1  one-cycle write request pulse; accepted only in IDLE.
REQ-005 valid_i  in  1  all byte groups ready (AND of bg_valid[3:0]).
REQ-006 nib_i  in  1  target nibble: 0 = lower, 1 = upper.
REQ-007 bg_i  in  2  target byte group 0..3.
REQ-008 addr_i  in  6  target RIU register address.
REQ-009 wr_data_i  in  16  data to write.
REQ-010 riu_rd_data_bg0..riu_rd_data_bg3  in  16 each  RIU read-back data per byte group; used only with RIU_WR_VERIFY_EN.
REQ-011 riu_addr  out  6  RIU address.
REQ-012 riu_nib_sel  out  2  RIU nibble select.
REQ-013 riu_wr_data  out  16  RIU write data.
REQ-014 riu_wr_en_bg  out  4  per-byte-group write strobe, one-hot or zero.
REQ-015 wr_done_o  out  1  one-cycle completion pulse.
REQ-016 busy_o  out  1  high whenever state is not IDLE.
REQ-017 err_o  out  1  timeout or verify-mismatch flag for the last request.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT_FOR_VALID, NIBBLE_SELECT, WRITE, SETTLE, READBACK (macro only) and DONE; all outputs SHALL be registered.
REQ-019 In IDLE, a trig_re sampled high SHALL capture addr_i, nib_i, bg_i and wr_data_i into holding registers, clear err_o, clear the timeout counter and move to WAIT_FOR_VALID.
REQ-020 Input changes after capture SHALL have no effect until the next accepted request; trig_re outside IDLE SHALL be ignored (no queuing).
REQ-021 WAIT_FOR_VALID: valid_i high SHALL move to NIBBLE_SELECT.
REQ-022 WAIT_FOR_VALID with valid_i low: the counter SHALL increment; when TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL move to DONE with err_o set and no write strobe issued.
REQ-023 riu_addr SHALL present the captured address from NIBBLE_SELECT through the last cycle before DONE, and hold its last value otherwise.
REQ-024 riu_nib_sel SHALL be 2'b01 (nib 0) or 2'b10 (nib 1) while in NIBBLE_SELECT, WRITE, SETTLE or READBACK, and 2'b00 in every other state.
REQ-025 WRITE SHALL last exactly one cycle, with riu_wr_en_bg[bg] = 1 and riu_wr_data = captured data; riu_wr_en_bg SHALL be 4'b0000 in all other states.
REQ-026 SETTLE SHALL last one cycle and then go to DONE, or to READBACK when the macro is defined.
REQ-027 DONE SHALL assert wr_done_o for exactly one cycle and return to IDLE; err_o SHALL hold until the next accepted trig_re.
REQ-028 Latency: trig_re at cycle 0 with valid_i high at cycle 1 SHALL give wr_done_o at cycle 5 (cycle 6 with the macro).
REQ-029 A trig_re coincident with wr_done_o SHALL be ignored; the FSM is not in IDLE during DONE.

Reset
REQ-030 rst SHALL immediately force state IDLE and clear the counter and holding registers.
REQ-031 rst SHALL drive riu_addr=0, riu_nib_sel=0, riu_wr_data=0, riu_wr_en_bg=0, wr_done_o=0, busy_o=0 and err_o=0, including mid-WRITE (strobe drops asynchronously).

Configuration
REQ-032 Macro RIU_WR_VERIFY_EN: when defined, READBACK SHALL sample riu_rd_data_bg[bg], set err_o on mismatch with the captured data, then go to DONE.
REQ-033 When RIU_WR_VERIFY_EN is undefined, READBACK and the read-data inputs SHALL be unused and SETTLE SHALL go directly to DONE.

Structure
REQ-034 Shared package riu_pkg SHALL hold: RIU_ADDR_W=6, RIU_DATA_W=16, NIB_LO=2'b01, NIB_HI=2'b10, and the write-FSM state encoding.
REQ-035 The timeout counter SHALL be a sub-module riu_wait_timer with ports clr, en, expired and parameter TIMEOUT_CYCLES.

Verification
REQ-036 trig_re with bg=2, nib=1, addr=6'h0A, data=16'h1234, valid_i high -> one cycle of riu_wr_en_bg=4'b0100, nib_sel=10, addr=0A, data=1234; wr_done_o at cycle 5; err_o=0.
REQ-037 valid_i held low, TIMEOUT_CYCLES=8 -> wr_done_o after 8 wait cycles with err_o=1, riu_wr_en_bg never nonzero; valid_i rising at wait cycle 5 -> normal write.
REQ-038 Second trig_re while busy, plus input changes after capture -> exactly one write, using the first captured values.
REQ-039 rst asserted during WRITE -> riu_wr_en_bg=0 with no clock edge, all outputs at reset values, next request completes normally.
REQ-040 With RIU_WR_VERIFY_EN, read-back 16'h1234 vs written 16'h1234 -> err_o=0 at cycle 6; read-back 16'h1235 -> err_o=1.

Source files
------------

// File: rtl/riu_pkg.sv
// Shared RIU definitions: bus widths, nibble-select codes, write-FSM states and
// the captured-request record.
package riu_pkg;

   localparam int RIU_ADDR_W = 6;
   localparam int RIU_DATA_W = 16;

   localparam logic [1:0] NIB_LO = 2'b01;
   localparam logic [1:0] NIB_HI = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_FOR_VALID,
      ST_NIBBLE_SELECT,
      ST_WRITE,
      ST_SETTLE,
      ST_READBACK,
      ST_DONE
   } wr_state_e;

   typedef struct packed {
      logic [RIU_ADDR_W-1:0] addr;
      logic                  nib;
      logic [1:0]            bg;
      logic [RIU_DATA_W-1:0] data;
   } riu_req_t;

   function automatic logic [1:0] nib_code(input logic nib);
      return nib ? NIB_HI : NIB_LO;
   endfunction

endpackage

// File: rtl/riu_wr_iodelay_if.sv
// Request/RIU signal bundle for the IODELAY register writer; slave is the
// writer side, master is the requester/RIU model side.
interface riu_wr_iodelay_if;
   import riu_pkg::*;

   logic                  trig_re;
   logic                  valid_i;
   logic                  nib_i;
   logic [1:0]            bg_i;
   logic [RIU_ADDR_W-1:0] addr_i;
   logic [RIU_DATA_W-1:0] wr_data_i;
   logic [RIU_DATA_W-1:0] riu_rd_data_bg0;
   logic [RIU_DATA_W-1:0] riu_rd_data_bg1;
   logic [RIU_DATA_W-1:0] riu_rd_data_bg2;
   logic [RIU_DATA_W-1:0] riu_rd_data_bg3;

   logic [RIU_ADDR_W-1:0] riu_addr;
   logic [1:0]            riu_nib_sel;
   logic [RIU_DATA_W-1:0] riu_wr_data;
   logic [3:0]            riu_wr_en_bg;
   logic                  wr_done_o;
   logic                  busy_o;
   logic                  err_o;

   modport slave (
      input  trig_re, valid_i, nib_i, bg_i, addr_i, wr_data_i,
             riu_rd_data_bg0, riu_rd_data_bg1, riu_rd_data_bg2, riu_rd_data_bg3,
      output riu_addr, riu_nib_sel, riu_wr_data, riu_wr_en_bg,
             wr_done_o, busy_o, err_o
   );

   modport master (
      output trig_re, valid_i, nib_i, bg_i, addr_i, wr_data_i,
             riu_rd_data_bg0, riu_rd_data_bg1, riu_rd_data_bg2, riu_rd_data_bg3,
      input  riu_addr, riu_nib_sel, riu_wr_data, riu_wr_en_bg,
             wr_done_o, busy_o, err_o
   );

endinterface

// File: rtl/riu_wait_timer.sv
// Wait counter for the write FSM; expired flags the last allowed wait cycle.
// TIMEOUT_CYCLES of 0 never expires.
module riu_wait_timer #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd1023
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [15:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + 16'd1;
   end

   assign expired = (TIMEOUT_CYCLES != 16'd0) && (cnt == TIMEOUT_CYCLES - 16'd1);

endmodule

// File: rtl/riu_wr_iodelay.sv
// Single RIU register write sequencer with wait-for-valid timeout.
// Optional read-back verify when RIU_WR_VERIFY_EN is defined.
module riu_wr_iodelay
   import riu_pkg::*;
#(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd1023
) (
   input  logic              clk,
   input  logic              rst,
   riu_wr_iodelay_if.slave   bus
);

   wr_state_e state, state_nxt;
   riu_req_t  req_q;
   logic      accept, err_nxt, tmr_en, expired;

   logic [RIU_ADDR_W-1:0] addr_q;
   logic [1:0]            nib_q;
   logic [RIU_DATA_W-1:0] data_q;
   logic [3:0]            en_q;
   logic                  done_q, busy_q, err_q;

   function automatic logic nib_active(input wr_state_e s);
      return (s == ST_NIBBLE_SELECT) || (s == ST_WRITE) ||
             (s == ST_SETTLE) || (s == ST_READBACK);
   endfunction

   riu_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .en      (tmr_en),
      .expired (expired)
   );

`ifdef RIU_WR_VERIFY_EN
   logic [RIU_DATA_W-1:0] rd_sel;
   always_comb begin
      rd_sel = bus.riu_rd_data_bg0;
      case (req_q.bg)
         2'd1:    rd_sel = bus.riu_rd_data_bg1;
         2'd2:    rd_sel = bus.riu_rd_data_bg2;
         2'd3:    rd_sel = bus.riu_rd_data_bg3;
         default: rd_sel = bus.riu_rd_data_bg0;
      endcase
   end
`else
   logic unused_rd;
   assign unused_rd = ^{bus.riu_rd_data_bg0, bus.riu_rd_data_bg1,
                        bus.riu_rd_data_bg2, bus.riu_rd_data_bg3};
`endif

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      err_nxt   = err_q;
      tmr_en    = 1'b0;
      case (state)
         ST_IDLE: if (bus.trig_re) begin
            accept    = 1'b1;
            err_nxt   = 1'b0;
            state_nxt = ST_WAIT_FOR_VALID;
         end
         // valid wins over an expiring counter in the same cycle
         ST_WAIT_FOR_VALID: if (bus.valid_i) begin
            state_nxt = ST_NIBBLE_SELECT;
         end else begin
            tmr_en = 1'b1;
            if (expired) begin
               state_nxt = ST_DONE;
               err_nxt   = 1'b1;
            end
         end
         ST_NIBBLE_SELECT: state_nxt = ST_WRITE;
         ST_WRITE:         state_nxt = ST_SETTLE;
`ifdef RIU_WR_VERIFY_EN
         ST_SETTLE:        state_nxt = ST_READBACK;
         ST_READBACK: begin
            if (rd_sel != req_q.data) err_nxt = 1'b1;
            state_nxt = ST_DONE;
         end
`else
         ST_SETTLE:        state_nxt = ST_DONE;
`endif
         ST_DONE:          state_nxt = ST_IDLE;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         req_q  <= '0;
         addr_q <= '0;
         nib_q  <= '0;
         data_q <= '0;
         en_q   <= '0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         err_q  <= err_nxt;
         if (accept) req_q <= '{addr: bus.addr_i, nib: bus.nib_i,
                                bg: bus.bg_i, data: bus.wr_data_i};
         if (nib_active(state_nxt)) addr_q <= req_q.addr;
         nib_q  <= nib_active(state_nxt) ? nib_code(req_q.nib) : 2'b00;
         if (state_nxt == ST_WRITE) data_q <= req_q.data;
         en_q   <= (state_nxt == ST_WRITE) ? (4'b0001 << req_q.bg) : 4'b0000;
         done_q <= (state_nxt == ST_DONE);
         busy_q <= (state_nxt != ST_IDLE);
      end
   end

   assign bus.riu_addr     = addr_q;
   assign bus.riu_nib_sel  = nib_q;
   assign bus.riu_wr_data  = data_q;
   assign bus.riu_wr_en_bg = en_q;
   assign bus.wr_done_o    = done_q;
   assign bus.busy_o       = busy_q;
   assign bus.err_o        = err_q;

endmodule

// File: tb/tb_riu_wr_iodelay.sv
// Directed bench for riu_wr_iodelay (TIMEOUT_CYCLES=8); cycle 0 is the cycle
// trig_re is driven, cycle k outputs are sampled on the falling edge after it.
module tb_riu_wr_iodelay;
   import riu_pkg::*;

`ifdef RIU_WR_VERIFY_EN
   localparam int XL = 1;
`else
   localparam int XL = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   riu_wr_iodelay_if bus();

   riu_wr_iodelay #(.TIMEOUT_CYCLES(16'd8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int          done_cyc;
      int          n_done;
      int          n_wr;
      logic [3:0]  en;
      logic [5:0]  addr;
      logic [1:0]  nib;
      logic [15:0] data;
      logic        err_done;
      logic        err_c1;
      logic        busy_end;
      logic        err_end;
   } obs_t;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One request; vcyc = cycle valid_i rises (0 = never); disturb re-pulses
   // trig_re and scrambles the inputs after capture and during DONE.
   task automatic run(input logic [1:0] bg, input logic nib, input logic [5:0] addr,
                      input logic [15:0] data, input int vcyc, input int ncyc,
                      input bit disturb, input bit mis, output obs_t o);
      o = '{default: 0};
      @(negedge clk);
      bus.bg_i = bg; bus.nib_i = nib; bus.addr_i = addr; bus.wr_data_i = data;
      bus.riu_rd_data_bg0 = mis ? data ^ 16'h0001 : data;
      bus.riu_rd_data_bg1 = bus.riu_rd_data_bg0;
      bus.riu_rd_data_bg2 = bus.riu_rd_data_bg0;
      bus.riu_rd_data_bg3 = bus.riu_rd_data_bg0;
      bus.trig_re = 1'b1; bus.valid_i = 1'b0;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (k == 1) o.err_c1 = bus.err_o;
         if (bus.wr_done_o) begin
            o.n_done++;
            if (o.done_cyc == 0) begin o.done_cyc = k; o.err_done = bus.err_o; end
         end
         if (bus.riu_wr_en_bg != 4'b0000) begin
            o.n_wr++;
            o.en = bus.riu_wr_en_bg; o.addr = bus.riu_addr;
            o.nib = bus.riu_nib_sel; o.data = bus.riu_wr_data;
         end
         if (k == ncyc) begin o.busy_end = bus.busy_o; o.err_end = bus.err_o; end
         bus.trig_re = disturb && (k == 2 || k == 5 + XL);
         bus.valid_i = (vcyc != 0) && (k >= vcyc);
         if (disturb && k == 2) begin
            bus.bg_i = ~bg; bus.nib_i = ~nib; bus.addr_i = addr ^ 6'h3F; bus.wr_data_i = ~data;
         end
      end
      bus.trig_re = 1'b0; bus.valid_i = 1'b0;
   endtask

   task automatic chk_wr(input string t, input obs_t o, input int done, input logic [3:0] en,
                         input logic [1:0] nib, input logic [5:0] addr, input logic [15:0] data,
                         input logic err);
      chk({t, "_done_cyc"}, o.done_cyc, done);
      chk({t, "_n_done"},   o.n_done, 1);
      chk({t, "_n_wr"},     o.n_wr, 1);
      chk({t, "_en"},       o.en, en);
      chk({t, "_nib"},      o.nib, nib);
      chk({t, "_addr"},     o.addr, addr);
      chk({t, "_data"},     o.data, data);
      chk({t, "_err"},      o.err_done, err);
      chk({t, "_busy_end"}, o.busy_end, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t o;
      bus.trig_re = 0; bus.valid_i = 0; bus.nib_i = 0; bus.bg_i = 0;
      bus.addr_i = 0; bus.wr_data_i = 0;
      bus.riu_rd_data_bg0 = 0; bus.riu_rd_data_bg1 = 0;
      bus.riu_rd_data_bg2 = 0; bus.riu_rd_data_bg3 = 0;

      @(negedge clk);
      chk("rst_outputs", {bus.riu_addr, bus.riu_nib_sel, bus.riu_wr_data, bus.riu_wr_en_bg,
                          bus.wr_done_o, bus.busy_o, bus.err_o}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      run(2'd2, 1'b1, 6'h0A, 16'h1234, 1, 8 + XL, 0, 0, o);
      chk_wr("basic", o, 5 + XL, 4'b0100, 2'b10, 6'h0A, 16'h1234, 1'b0);

      run(2'd1, 1'b0, 6'h05, 16'hABCD, 0, 12, 0, 0, o);
      chk("tmo_done_cyc", o.done_cyc, 9);
      chk("tmo_n_done",   o.n_done, 1);
      chk("tmo_err",      o.err_done, 1'b1);
      chk("tmo_n_wr",     o.n_wr, 0);
      chk("tmo_err_hold", o.err_end, 1'b1);
      chk("tmo_busy_end", o.busy_end, 1'b0);

      run(2'd0, 1'b0, 6'h3F, 16'hFFFF, 5, 12 + XL, 0, 0, o);
      chk("late_err_clr", o.err_c1, 1'b0);
      chk_wr("late", o, 9 + XL, 4'b0001, 2'b01, 6'h3F, 16'hFFFF, 1'b0);

      run(2'd3, 1'b1, 6'h15, 16'h0F0F, 8, 15 + XL, 0, 0, o);
      chk_wr("edge8", o, 12 + XL, 4'b1000, 2'b10, 6'h15, 16'h0F0F, 1'b0);

      run(2'd1, 1'b0, 6'h21, 16'h5A5A, 1, 11 + XL, 1, 0, o);
      chk_wr("busy_trig", o, 5 + XL, 4'b0010, 2'b01, 6'h21, 16'h5A5A, 1'b0);

      // reset landing in the WRITE cycle
      @(negedge clk);
      bus.bg_i = 2'd2; bus.nib_i = 1'b0; bus.addr_i = 6'h11; bus.wr_data_i = 16'h7777;
      bus.trig_re = 1'b1; bus.valid_i = 1'b0;
      @(negedge clk); bus.trig_re = 1'b0; bus.valid_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("prerst_en", bus.riu_wr_en_bg, 4'b0100);
      rst = 1'b1;
      #1;
      chk("midrst_en", bus.riu_wr_en_bg, 4'b0000);
      chk("midrst_outputs", {bus.riu_addr, bus.riu_nib_sel, bus.riu_wr_data,
                             bus.wr_done_o, bus.busy_o, bus.err_o}, 32'h0);
      @(negedge clk);
      rst = 1'b0; bus.valid_i = 1'b0;
      @(negedge clk);

      run(2'd3, 1'b0, 6'h2C, 16'hBEEF, 1, 8 + XL, 0, 0, o);
      chk_wr("postrst", o, 5 + XL, 4'b1000, 2'b01, 6'h2C, 16'hBEEF, 1'b0);

      run(2'd1, 1'b1, 6'h0A, 16'h1234, 1, 8 + XL, 0, 1, o);
      chk_wr("verify_mis", o, 5 + XL, 4'b0010, 2'b10, 6'h0A, 16'h1234, XL != 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
